vec_reg_loader: RTL and testbench
=================================

# vec_reg_loader

Parametrised vector load sequencer between the memory read path and the weight/spike vector register files. It accepts a decoded load command (3-bit funct + destination register index), gathers a full vector from a narrower memory beat stream under valid/ready handshake, and issues one registered write to the vector register file. It generalises the fixed 512-bit single-shot load path: it adds configurable lane count and width, multi-beat assembly, per-lane write masks, broadcast and scalar modes, and back-pressure.

## Interface
Parameters:
- LANES, 16, lanes per vector
- LANE_W, 32, bits per lane
- BEAT_W, 128, memory beat width. Must divide LANES*LANE_W and be >= LANE_W.
- RD_W, 5, register index width (32 registers)
- Derived: VEC_W = LANES*LANE_W; BEATS = VEC_W/BEAT_W (4 at defaults)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_funct  in  3  load mode
- cmd_rd  in  RD_W  destination register
- beat_valid  in  1  memory beat offered
- beat_ready  out  1  beat accepted when beat_valid && beat_ready
- beat_data  in  BEAT_W  beat payload
- vrf_we  out  1  one-cycle register-file write strobe
- vrf_waddr  out  RD_W  write address
- vrf_wdata  out  VEC_W  write data
- vrf_wmask  out  LANES  per-lane write enable, bit i = lane i
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse on illegal funct

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE: cmd_ready=1, beat_ready=0. On command handshake:
  - Latch funct and rd, and clear the assembly buffer to 0.
  - Set the beat counter to 0. Set need = BEATS for funct 000, else 1.
  - Legal funct -> COLLECT.
  - Illegal funct (011-111) -> err=1 next cycle, stay IDLE, nothing latched.
- COLLECT: cmd_ready=0, beat_ready=1.
  - Each beat handshake writes beat_data into buffer bits [cnt*BEAT_W +: BEAT_W]; beat 0 is LSB. Counter increments.
  - The handshake on beat need-1 -> WRITE.
- WRITE: vrf_we=1 for exactly this cycle, with vrf_waddr = latched rd. Next state is IDLE.
- Modes:
  - 000 full: wdata = buffer, wmask = all ones.
  - 001 scalar: lane 0 = beat_data[LANE_W-1:0]; other lanes 0; wmask = 1 (lane 0 only).
  - 010 broadcast: every lane = beat_data[LANE_W-1:0]; wmask = all ones.
- Beat bits above LANE_W in modes 001/010 are ignored.
- vrf_wdata, vrf_wmask and vrf_waddr are registered. They hold their last value outside WRITE. Only vrf_we qualifies them.
- Boundary conditions:
  - beat_valid in IDLE or WRITE is ignored; no handshake.
  - cmd_valid in COLLECT or WRITE is stalled.
  - Gaps in beat_valid extend COLLECT indefinitely; there is no timeout.
  - Reset asserted mid-COLLECT discards the partial vector, returns to IDLE, and produces no vrf_we.
  - The counter never wraps, because the transition out of COLLECT happens on the final beat.

## Timing
- Reset values: state=IDLE, cmd_ready=1, beat_ready=0, vrf_we=0, vrf_waddr=0, vrf_wdata=0, vrf_wmask=0, busy=0, err=0.
- cmd_ready and beat_ready are decoded combinationally from state only. They have no combinational path from the valid inputs.
- Command handshake at edge t -> busy=1 and beat_ready=1 from t+1.
- Final beat handshake at edge t -> vrf_we=1 in cycle t+1 -> cmd_ready=1 in cycle t+2.
- Full load with no gaps: 1 (cmd) + 4 (beats) + 1 (write) = 6 cycles per command at defaults. Minimum command-to-command spacing is BEATS+2.
- err asserts in the cycle after the illegal command handshake, for one cycle. The next command can be accepted in that same cycle.

## Test plan
- Full load: funct 000, rd 3, four beats, each of the form 128'h44444444_33333333_22222222_11111111 with beat index k added to each word.
  - Expect vrf_we one cycle after beat 3, waddr=3, wmask=16'hFFFF.
  - Expect wdata[127:0] = beat 0 and wdata[511:384] = beat 3.
- Scalar: funct 001, rd 5, beat with low word 32'h11111234 and upper bits all F.
  - Expect wdata = 512'h11111234 (all other lanes 0), wmask=16'h0001, waddr=5, one beat consumed.
- Broadcast: funct 010, rd 1, low word 32'hFFFF0001.
  - Expect all 16 lanes = FFFF0001, wmask=16'hFFFF, vrf_we a single-cycle pulse.
- Back-pressure:
  - Repeat the full-load test with beat_valid low for 3 cycles between beats. Expect identical wdata.
  - Hold cmd_valid high throughout. Expect it not accepted until cmd_ready returns, 2 cycles after the final beat.
- Illegal funct 111: expect a single err pulse, no vrf_we, busy stays 0. A following funct 000 load completes normally.
- Reset mid-operation: drop reset after 2 of 4 beats.
  - Expect all outputs at reset values and no vrf_we.
  - A subsequent full load to rd 7 writes only the new data.

Source files
------------

// File: rtl/vec_reg_loader.sv
// Vector load sequencer: takes a load command, gathers BEATS memory beats into one
// vector and issues a single registered write (full, scalar or broadcast) to the VRF.

module vec_reg_lane #(
    parameter int LANE_W   = 32,
    parameter int LANE_IDX = 0
) (
    input  logic [2:0]        funct_i,
    input  logic [LANE_W-1:0] full_i,
    input  logic [LANE_W-1:0] word_i,
    output logic [LANE_W-1:0] data_o,
    output logic              mask_o
);
    localparam bit IS_LANE0 = (LANE_IDX == 0);

    always_comb begin
        data_o = '0;
        mask_o = 1'b0;
        case (funct_i)
            3'b000: begin
                data_o = full_i;
                mask_o = 1'b1;
            end
            3'b001: begin
                data_o = IS_LANE0 ? word_i : '0;
                mask_o = IS_LANE0;
            end
            3'b010: begin
                data_o = word_i;
                mask_o = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

module vec_reg_loader #(
    parameter  int LANES  = 16,
    parameter  int LANE_W = 32,
    parameter  int BEAT_W = 128,
    parameter  int RD_W   = 5,
    localparam int VEC_W  = LANES * LANE_W,
    localparam int BEATS  = VEC_W / BEAT_W
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_funct_i,
    input  logic [RD_W-1:0]   cmd_rd_i,
    input  logic              beat_valid_i,
    output logic              beat_ready_o,
    input  logic [BEAT_W-1:0] beat_data_i,
    output logic              vrf_we_o,
    output logic [RD_W-1:0]   vrf_waddr_o,
    output logic [VEC_W-1:0]  vrf_wdata_o,
    output logic [LANES-1:0]  vrf_wmask_o,
    output logic              busy_o,
    output logic              err_o
);
    // One spare bit so the counter can also hold need = BEATS.
    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_t;

    typedef struct packed {
        logic [2:0]      funct;
        logic [RD_W-1:0] rd;
    } cmd_t;

    state_t                          state_q;
    cmd_t                            cmd_q;
    logic [BEATS-1:0][BEAT_W-1:0]    buf_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [CNT_W-1:0]                need_q;
    logic                            vrf_we_q;
    logic [RD_W-1:0]                 vrf_waddr_q;
    logic [VEC_W-1:0]                vrf_wdata_q;
    logic [LANES-1:0]                vrf_wmask_q;
    logic                            err_q;

    logic [BEATS-1:0][BEAT_W-1:0]    asm_vec;
    logic [LANES-1:0][LANE_W-1:0]    asm_lanes;
    logic [LANES-1:0][LANE_W-1:0]    lane_data;
    logic [LANES-1:0]                lane_mask;
    logic                            last_beat;
    logic                            legal;

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign beat_ready_o = (state_q == S_COLLECT);
    assign busy_o       = (state_q != S_IDLE);
    assign vrf_we_o     = vrf_we_q;
    assign vrf_waddr_o  = vrf_waddr_q;
    assign vrf_wdata_o  = vrf_wdata_q;
    assign vrf_wmask_o  = vrf_wmask_q;
    assign err_o        = err_q;

    assign legal     = (cmd_funct_i < 3'd3);
    assign last_beat = (cnt_q == need_q - CNT_W'(1));

    // The incoming beat is merged into the buffer so the final write can be
    // registered on the same edge that accepts the last beat.
    for (genvar b = 0; b < BEATS; b++) begin : g_asm
        assign asm_vec[b] = (cnt_q == CNT_W'(b)) ? beat_data_i : buf_q[b];
    end

    assign asm_lanes = asm_vec;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vec_reg_lane #(
            .LANE_W   (LANE_W),
            .LANE_IDX (l)
        ) u_lane (
            .funct_i (cmd_q.funct),
            .full_i  (asm_lanes[l]),
            .word_i  (beat_data_i[LANE_W-1:0]),
            .data_o  (lane_data[l]),
            .mask_o  (lane_mask[l])
        );
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            need_q      <= '0;
            vrf_we_q    <= 1'b0;
            vrf_waddr_q <= '0;
            vrf_wdata_q <= '0;
            vrf_wmask_q <= '0;
            err_q       <= 1'b0;
        end else begin
            vrf_we_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        if (legal) begin
                            cmd_q   <= '{funct: cmd_funct_i, rd: cmd_rd_i};
                            buf_q   <= '0;
                            cnt_q   <= '0;
                            need_q  <= (cmd_funct_i == 3'b000) ? CNT_W'(BEATS) : CNT_W'(1);
                            state_q <= S_COLLECT;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (beat_valid_i) begin
                        buf_q <= asm_vec;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            vrf_we_q    <= 1'b1;
                            vrf_waddr_q <= cmd_q.rd;
                            vrf_wdata_q <= lane_data;
                            vrf_wmask_q <= lane_mask;
                            state_q     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vec_reg_loader.sv
// Bench for vec_reg_loader: directed vector table, random loads against a
// spec-level model, and hand-written back-pressure / illegal / reset sequences.

module tb_vec_reg_loader;
    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_funct;
    logic [4:0]       cmd_rd;
    logic             beat_valid;
    logic             beat_ready;
    logic [127:0]     beat_data;
    logic             vrf_we;
    logic [4:0]       vrf_waddr;
    logic [511:0]     vrf_wdata;
    logic [15:0]      vrf_wmask;
    logic             busy;
    logic             err;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [2:0]        funct;
        logic [4:0]        rd;
        logic [3:0][127:0] b;
        int                gap;
        logic [511:0]      exp_data;
        logic [15:0]       exp_mask;
    } vec_t;

    vec_reg_loader dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_funct_i  (cmd_funct),
        .cmd_rd_i     (cmd_rd),
        .beat_valid_i (beat_valid),
        .beat_ready_o (beat_ready),
        .beat_data_i  (beat_data),
        .vrf_we_o     (vrf_we),
        .vrf_waddr_o  (vrf_waddr),
        .vrf_wdata_o  (vrf_wdata),
        .vrf_wmask_o  (vrf_wmask),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vrf_we) we_cnt++;
        if (err) err_cnt++;
    end

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Expected write from the load rules: full concatenates beats, scalar puts the
    // low word of beat 0 in lane 0, broadcast replicates it across all lanes.
    function automatic void model(input logic [2:0] f, input logic [3:0][127:0] b,
                                  output logic [511:0] d, output logic [15:0] m);
        d = '0;
        m = '0;
        case (f)
            3'd0: begin
                for (int k = 0; k < 4; k++) d[k*128 +: 128] = b[k];
                m = 16'hFFFF;
            end
            3'd1: begin
                d[31:0] = b[0][31:0];
                m = 16'h0001;
            end
            3'd2: begin
                for (int i = 0; i < 16; i++) d[i*32 +: 32] = b[0][31:0];
                m = 16'hFFFF;
            end
            default: ;
        endcase
    endfunction

    task automatic send_cmd(input logic [2:0] f, input logic [4:0] rd);
        int n = 0;
        cmd_funct = f;
        cmd_rd    = rd;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL cmd_timeout got=no_ready exp=ready");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [127:0] d, input int gap);
        int n = 0;
        beat_valid = 1'b0;
        repeat (gap) @(negedge clk);
        beat_data  = d;
        beat_valid = 1'b1;
        while (!beat_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL beat_timeout got=no_ready exp=ready");
        end
        @(negedge clk);
        beat_valid = 1'b0;
    endtask

    // Called in the cycle after the final beat handshake.
    task automatic check_write(input logic [4:0] rd, input logic [511:0] d, input logic [15:0] m);
        chk("we",        512'(vrf_we),    512'(1));
        chk("waddr",     512'(vrf_waddr), 512'(rd));
        chk("wdata",     vrf_wdata,       d);
        chk("wmask",     512'(vrf_wmask), 512'(m));
        chk("busy_wr",   512'(busy),      512'(1));
        chk("cmdrdy_wr", 512'(cmd_ready), 512'(0));
        chk("beatrdy_wr",512'(beat_ready),512'(0));
        @(negedge clk);
        chk("we_pulse",  512'(vrf_we),    512'(0));
        chk("cmdrdy_idle",512'(cmd_ready),512'(1));
        chk("wdata_hold",vrf_wdata,       d);
    endtask

    task automatic run_vec(input vec_t v);
        int nb;
        send_cmd(v.funct, v.rd);
        chk("busy_cmd", 512'(busy), 512'(1));
        nb = (v.funct == 3'd0) ? 4 : 1;
        for (int k = 0; k < nb; k++) send_beat(v.b[k], (k > 0) ? v.gap : 0);
        check_write(v.rd, v.exp_data, v.exp_mask);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cmdrdy",  512'(cmd_ready),  512'(1));
        chk("rst_beatrdy", 512'(beat_ready), 512'(0));
        chk("rst_we",      512'(vrf_we),     512'(0));
        chk("rst_waddr",   512'(vrf_waddr),  512'(0));
        chk("rst_wdata",   vrf_wdata,        512'(0));
        chk("rst_wmask",   512'(vrf_wmask),  512'(0));
        chk("rst_busy",    512'(busy),       512'(0));
        chk("rst_err",     512'(err),        512'(0));
    endtask

    vec_t tbl[4];
    vec_t v;
    logic [3:0][127:0] seq_b;
    logic [127:0] base;
    int snap_we, snap_err;

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; beat_valid = 1'b0;
        cmd_funct = '0; cmd_rd = '0; beat_data = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        reset_n = 1'b1;
        @(negedge clk);

        base = 128'h44444444_33333333_22222222_11111111;
        tbl[0].funct = 3'd0; tbl[0].rd = 5'd3; tbl[0].gap = 0;
        for (int k = 0; k < 4; k++) tbl[0].b[k] = base + {4{32'(k)}};
        tbl[0].exp_data = {128'h44444447_33333336_22222225_11111114,
                           128'h44444446_33333335_22222224_11111113,
                           128'h44444445_33333334_22222223_11111112,
                           128'h44444444_33333333_22222222_11111111};
        tbl[0].exp_mask = 16'hFFFF;
        tbl[1].funct = 3'd1; tbl[1].rd = 5'd5; tbl[1].gap = 0;
        tbl[1].b = '0;
        tbl[1].b[0] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h11111234};
        tbl[1].exp_data = 512'h11111234;
        tbl[1].exp_mask = 16'h0001;
        tbl[2].funct = 3'd2; tbl[2].rd = 5'd1; tbl[2].gap = 0;
        tbl[2].b = '0;
        tbl[2].b[0] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'hFFFF0001};
        tbl[2].exp_data = {16{32'hFFFF0001}};
        tbl[2].exp_mask = 16'hFFFF;
        tbl[3] = tbl[0];
        tbl[3].gap = 3;

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            v.funct = 3'($urandom_range(0, 2));
            v.rd    = 5'($urandom);
            v.gap   = $urandom_range(0, 2);
            for (int k = 0; k < 4; k++) v.b[k] = {$urandom, $urandom, $urandom, $urandom};
            model(v.funct, v.b, v.exp_data, v.exp_mask);
            run_vec(v);
        end

        // cmd_valid held high across a whole load: next accept 2 cycles after last beat
        for (int k = 0; k < 4; k++) seq_b[k] = {$urandom, $urandom, $urandom, $urandom};
        cmd_funct = 3'd0; cmd_rd = 5'd2; cmd_valid = 1'b1;
        @(negedge clk);
        chk("hold_busy",   512'(busy),      512'(1));
        chk("hold_cmdrdy", 512'(cmd_ready), 512'(0));
        for (int k = 0; k < 4; k++) send_beat(seq_b[k], 1);
        chk("hold_we",     512'(vrf_we),    512'(1));
        chk("hold_cmdrdy1",512'(cmd_ready), 512'(0));
        chk("hold_wdata",  vrf_wdata,       {seq_b[3], seq_b[2], seq_b[1], seq_b[0]});
        @(negedge clk);
        chk("hold_cmdrdy2",512'(cmd_ready), 512'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("hold_reaccept", 512'(busy), 512'(1));
        for (int k = 0; k < 4; k++) seq_b[k] = ~seq_b[k];
        for (int k = 0; k < 4; k++) send_beat(seq_b[k], 0);
        check_write(5'd2, {seq_b[3], seq_b[2], seq_b[1], seq_b[0]}, 16'hFFFF);

        // illegal funct, then a legal command offered in the err cycle
        snap_we = we_cnt; snap_err = err_cnt;
        cmd_funct = 3'd7; cmd_rd = 5'd9; cmd_valid = 1'b1;
        @(negedge clk);
        chk("ill_err",    512'(err),       512'(1));
        chk("ill_busy",   512'(busy),      512'(0));
        chk("ill_cmdrdy", 512'(cmd_ready), 512'(1));
        cmd_funct = 3'd0; cmd_rd = 5'd4;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("ill_err_pulse", 512'(err),  512'(0));
        chk("ill_next_busy", 512'(busy), 512'(1));
        chk("ill_no_we",     512'(we_cnt),  512'(snap_we));
        chk("ill_err_cnt",   512'(err_cnt), 512'(snap_err + 1));
        for (int k = 0; k < 4; k++) send_beat(seq_b[k] ^ {4{32'(k)}}, 0);
        model(3'd0, seq_b ^ {32'(3), 32'(3), 32'(3), 32'(3), 32'(2), 32'(2), 32'(2), 32'(2),
                             32'(1), 32'(1), 32'(1), 32'(1), 32'(0), 32'(0), 32'(0), 32'(0)},
              v.exp_data, v.exp_mask);
        check_write(5'd4, v.exp_data, v.exp_mask);

        // beat_valid while idle is ignored
        snap_we = we_cnt;
        beat_data = '1; beat_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_beatrdy", 512'(beat_ready), 512'(0));
        chk("idle_busy",    512'(busy),       512'(0));
        beat_valid = 1'b0;
        @(negedge clk);
        chk("idle_no_we",   512'(we_cnt),     512'(snap_we));

        // reset after 2 of 4 beats
        snap_we = we_cnt;
        send_cmd(3'd0, 5'd6);
        send_beat(128'hAAAA, 0);
        send_beat(128'hBBBB, 0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_no_we", 512'(we_cnt), 512'(snap_we));
        v.funct = 3'd0; v.rd = 5'd7; v.gap = 0;
        for (int k = 0; k < 4; k++) v.b[k] = {$urandom, $urandom, $urandom, $urandom};
        model(v.funct, v.b, v.exp_data, v.exp_mask);
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
